// File: rtl/vga_scan_gen_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_scan_gen_if
// Bundles the scan generator's pixel-side signals.
//   pix_en      : pixel-rate strobe into the generator
//   pixel_x/y   : current scan coordinate out to sprite renderers
//   color_in    : composited {R,G,B} returned by the renderers
//   color_out   : registered pixel to the DAC
//   hsync_n     : active-low sync aligned with color_out
//   vsync_n     : active-low sync aligned with color_out
//   blank       : high outside the visible area, aligned with color_out
//   frame_start : one-clock pulse at the start of each frame
// The generator connects through the slave modport.
// The pixel source/sink (renderers, DAC, bench) connects through master.
// -----------------------------------------------------------------------------
interface vga_scan_gen_if;
    logic        pix_en;
    logic [15:0] pixel_x;
    logic [15:0] pixel_y;
    logic [23:0] color_in;
    logic [23:0] color_out;
    logic        hsync_n;
    logic        vsync_n;
    logic        blank;
    logic        frame_start;

    modport slave (
        input  pix_en, color_in,
        output pixel_x, pixel_y, color_out, hsync_n, vsync_n, blank, frame_start
    );

    modport master (
        output pix_en, color_in,
        input  pixel_x, pixel_y, color_out, hsync_n, vsync_n, blank, frame_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_scan_gen
// Raster scan generator. Horizontal and vertical counters advance on the
// pixel strobe and are presented directly as the scan coordinate.
// Blanking and sync timing is derived from the counters. It is then delayed
// by LAT clocks so that it lines up with the renderer's colour for the same
// coordinate. After that delay, all DAC-side outputs are registered together.
// Ports:
//   clk : single rising-edge clock
//   rst : asynchronous active-low reset
//   bus : vga_scan_gen_if.slave
//         in  : pix_en, color_in
//         out : pixel_x, pixel_y, color_out, hsync_n, vsync_n, blank,
//               frame_start
// -----------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LAT      = 1
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.slave  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_LIM  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_LIM  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_FIRST   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_LAST    = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [15:0]    h_cnt_q, h_cnt_d;
    logic [15:0]    v_cnt_q, v_cnt_d;
    logic [LAT-1:0] act_pipe_q, act_pipe_d;
    logic [LAT-1:0] hs_pipe_q,  hs_pipe_d;
    logic [LAT-1:0] vs_pipe_q,  vs_pipe_d;
    logic [23:0]    color_out_q, color_out_d;
    logic           hsync_n_q, hsync_n_d;
    logic           vsync_n_q, vsync_n_d;
    logic           blank_q, blank_d;
    logic           frame_start_q, frame_start_d;

    logic           h_wrap_s;
    logic           v_wrap_s;
    logic           act_raw_s;
    logic           hs_raw_n_s;
    logic           vs_raw_n_s;
    logic           act_dly_s;

    // Next-state logic for the counters, delay pipeline and DAC-side outputs
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_wrap_s = (h_cnt_q == H_LAST);
        v_wrap_s = (v_cnt_q == V_LAST);

        // pixel_y moves on the same strobe that wraps h, once per line
        if (bus.pix_en) begin
            if (h_wrap_s) begin
                h_cnt_d = 16'd0;
                if (v_wrap_s) begin
                    v_cnt_d = 16'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 16'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end

        act_raw_s  = (h_cnt_q < H_ACT_LIM) && (v_cnt_q < V_ACT_LIM);
        hs_raw_n_s = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_raw_n_s = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

        // Stage 0 takes the raw value; the oldest stage is bit LAT-1.
        // The pipeline shifts every clock, so it matches the renderer's clock-based latency.
        act_pipe_d    = act_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        act_pipe_d[0] = act_raw_s;
        hs_pipe_d[0]  = hs_raw_n_s;
        vs_pipe_d[0]  = vs_raw_n_s;
        for (int i = 1; i < LAT; i++) begin
            act_pipe_d[i] = act_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
        end

        act_dly_s = act_pipe_q[LAT-1];
        hsync_n_d = hs_pipe_q[LAT-1];
        vsync_n_d = vs_pipe_q[LAT-1];
        blank_d   = !act_dly_s;

        if (act_dly_s) begin
            color_out_d = bus.color_in;
        end else begin
            color_out_d = 24'h000000;
        end

        frame_start_d = bus.pix_en && h_wrap_s && v_wrap_s;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q       <= 16'd0;
            v_cnt_q       <= 16'd0;
            act_pipe_q    <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            color_out_q   <= 24'h000000;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            act_pipe_q    <= act_pipe_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            color_out_q   <= color_out_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pixel_x     = h_cnt_q;
    assign bus.pixel_y     = v_cnt_q;
    assign bus.color_out   = color_out_q;
    assign bus.hsync_n     = hsync_n_q;
    assign bus.vsync_n     = vsync_n_q;
    assign bus.blank       = blank_q;
    assign bus.frame_start = frame_start_q;

endmodule
